// File: rtl/risc_pipeline_sequencer.sv
// Control FSM for the 4-stage RISC pipeline: clears the register file after reset,
// issues 1..4 instructions, tracks per-stage valid bits and gates register-file writes.
module risc_pipeline_sequencer #(
    parameter int          RF_CLR_CYCLES = 2,
    parameter logic [1:0]  NOP_TYPE      = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    input  logic       halt_req,
    input  logic [1:0] start_pc,
    input  logic [2:0] num_inst,
    input  logic [1:0] exe_mem_type,
    output logic [1:0] pc_in,
    output logic       im_cs,
    output logic       rf_reset,
    output logic       rf_we,
    output logic [3:0] stage_valid,
    output logic       busy,
    output logic       done
);

    localparam int CW = (RF_CLR_CYCLES > 1) ? $clog2(RF_CLR_CYCLES) : 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(RF_CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        RF_CLR = 2'd0,
        IDLE   = 2'd1,
        ISSUE  = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] clr_cnt_reg;
    logic [1:0]    addr_reg;
    logic [1:0]    pc_reg;
    logic [2:0]    remaining_reg;
    logic          im_cs_reg;
    logic          rf_reset_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [3:0]    valid_reg;
    logic [3:0]    valid_next;
    logic          valid_in;
    logic [2:0]    num_clamped;

    // An instruction enters the pipe only from ISSUE and never in a halted cycle.
    assign valid_in    = (state_reg == ISSUE) && !halt_req;
    assign num_clamped = (num_inst > 3'd4) ? 3'd4 : num_inst;

    assign valid_next[0] = valid_in;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_valid_shift
            assign valid_next[gi] = valid_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RF_CLR;
            clr_cnt_reg   <= '0;
            addr_reg      <= 2'd0;
            pc_reg        <= 2'd0;
            remaining_reg <= 3'd0;
            im_cs_reg     <= 1'b0;
            rf_reset_reg  <= 1'b1;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
            valid_reg     <= 4'd0;
        end else begin
            valid_reg <= valid_next;
            done_reg  <= 1'b0;
            case (state_reg)
                RF_CLR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        state_reg    <= IDLE;
                        rf_reset_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                IDLE: begin
                    im_cs_reg <= 1'b0;
                    if (start) begin
                        if (num_clamped != 3'd0) begin
                            addr_reg      <= start_pc;
                            remaining_reg <= num_clamped;
                            state_reg     <= ISSUE;
                            busy_reg      <= 1'b1;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end else if (step) begin
                        addr_reg      <= start_pc;
                        remaining_reg <= 3'd1;
                        state_reg     <= ISSUE;
                        busy_reg      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (halt_req) begin
                        im_cs_reg <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        pc_reg        <= addr_reg;
                        im_cs_reg     <= 1'b1;
                        addr_reg      <= addr_reg + 2'd1;
                        remaining_reg <= remaining_reg - 3'd1;
                        if (remaining_reg == 3'd1) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    im_cs_reg <= 1'b0;
                    // Finish on the edge that shifts the last valid bit out of EXE/MEM.
                    if (valid_next == 4'd0) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= RF_CLR;
            endcase
        end
    end

    assign pc_in       = pc_reg;
    assign im_cs       = im_cs_reg;
    assign rf_reset    = rf_reset_reg;
    assign stage_valid = valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign rf_we       = valid_reg[3] && (exe_mem_type != NOP_TYPE);

endmodule
